// File: rtl/fetch_pc_stage.sv
// -----------------------------------------------------------------------------
// fetch_pc_stage
//   Program-counter register and IF/ID pipeline register for the pipelined
//   RV32I core. The PC drives instruction memory and the next-PC mux; the mux
//   result comes back on next_pc_in. Each accepted fetch latches
//   {pc, pc+4, instruction} into IF/ID. Stall and flush from the hazard unit
//   are applied here, and an ebreak/ecall decode parks fetch in HALT until reset.
//
//   Optional feature macro: FETCH_PERF_CNT_EN
//     When defined, the block gains saturating 32-bit performance counters
//     fetch_cnt, stall_cnt and flush_cnt. All three are cleared on rst.
//
//   Ports:
//     clk, rst        rising-edge clock, synchronous active-high reset
//     next_pc_in      selected next PC from the next-PC mux
//     instr_in        imem read data for pc_out (combinational memory)
//     stall, flush    hazard unit controls
//     halt_req        ebreak/ecall decoded, stop fetching
//     pc_out          current PC / imem address
//     pc_plus4_out    pc_out + 4, wraps modulo 2^N
//     if_id_*         IF/ID register contents and valid flag
//     halted          fetch is parked in HALT
//     misalign_err    one-cycle pulse after accepting a misaligned next PC
//     fetch_cnt, stall_cnt, flush_cnt   (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_pc_stage #(
    parameter int unsigned     N        = 32,
    parameter logic [N-1:0]    RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] next_pc_in,
    input  logic [31:0]  instr_in,
    input  logic         stall,
    input  logic         flush,
    input  logic         halt_req,
    output logic [N-1:0] pc_out,
    output logic [N-1:0] pc_plus4_out,
    output logic [N-1:0] if_id_pc,
    output logic [N-1:0] if_id_pc_plus4,
    output logic [31:0]  if_id_instr,
    output logic         if_id_valid,
    output logic         halted,
    output logic         misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_cnt,
    output logic [31:0]  stall_cnt,
    output logic [31:0]  flush_cnt
`endif
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] if_id_pc_q, if_id_pc_d;
    logic [N-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [31:0]  if_id_instr_q, if_id_instr_d;
    logic         if_id_valid_q, if_id_valid_d;
    logic         misalign_q, misalign_d;

    logic [N-1:0] pc_plus4;
    logic [N-1:0] next_pc_aligned;
    logic         next_pc_misaligned;
    logic         in_run;
    logic         do_redirect;
    logic         do_halt;
    logic         do_stall;
    logic         do_fetch;

    assign pc_plus4           = pc_q + N'(4);
    assign next_pc_aligned    = {next_pc_in[N-1:2], 2'b00};
    assign next_pc_misaligned = (next_pc_in[1:0] != 2'b00);

    // Resolve flush > halt_req > stall > fetch once, so the state and
    // datapath logic below share a single view of what this edge does.
    // A flush in HALT only bubbles IF/ID; the PC stays frozen.
    assign in_run      = (state_q == RUN);
    assign do_redirect = in_run && flush;
    assign do_halt     = in_run && !flush && halt_req;
    assign do_stall    = in_run && !flush && !halt_req && stall;
    assign do_fetch    = in_run && !flush && !halt_req && !stall;

    // State register and all pipeline flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            pc_q             <= RESET_PC;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= '0;
            if_id_instr_q    <= NOP;
            if_id_valid_q    <= 1'b0;
            misalign_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_valid_q    <= if_id_valid_d;
            misalign_q       <= misalign_d;
        end
    end

    // Next state: HALT is left only through reset. A halt_req that arrives
    // with flush belongs to a squashed instruction and is ignored.
    always_comb begin
        state_d = state_q;
        if (do_halt) begin
            state_d = HALT;
        end
    end

    // Datapath next values. Anything that is not a fetch or a stall puts a
    // bubble in IF/ID. Only redirect and fetch move the PC, so only those
    // can raise the misalign pulse.
    always_comb begin
        pc_d             = pc_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_valid_d    = if_id_valid_q;
        misalign_d       = 1'b0;

        if (do_fetch) begin
            pc_d             = next_pc_aligned;
            if_id_pc_d       = pc_q;
            if_id_pc_plus4_d = pc_plus4;
            if_id_instr_d    = instr_in;
            if_id_valid_d    = 1'b1;
            misalign_d       = next_pc_misaligned;
        end else if (!do_stall) begin
            if_id_pc_d       = '0;
            if_id_pc_plus4_d = '0;
            if_id_instr_d    = NOP;
            if_id_valid_d    = 1'b0;
            if (do_redirect) begin
                pc_d       = next_pc_aligned;
                misalign_d = next_pc_misaligned;
            end
        end
    end

    // Outputs come straight from the flops, except pc_plus4_out, which
    // the next-PC mux needs in the same cycle.
    always_comb begin
        pc_out         = pc_q;
        pc_plus4_out   = pc_plus4;
        if_id_pc       = if_id_pc_q;
        if_id_pc_plus4 = if_id_pc_plus4_q;
        if_id_instr    = if_id_instr_q;
        if_id_valid    = if_id_valid_q;
        halted         = (state_q == HALT);
        misalign_err   = misalign_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters. A flush is counted in either state.
    // A stall is counted only when it actually holds the pipe in RUN.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (do_fetch && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (do_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
